instr_encoder: RTL

Packs mnemonic-level instruction fields into 32-bit MIPS instruction words and writes them sequentially into instruction memory. It is the producing end of the opcode/funct encoding that the control decoder consumes. It is used by test benches and the boot path to load programs. A small FIFO decouples the field-input handshake from the memory write handshake.

---
 rtl/instr_encoder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS mnemonic fields into 32-bit words and streams them into instruction memory.
// Latency: a bundle accepted at edge N into an empty, idle block raises imem_we from edge N+1.
// Backpressure: in_ready drops when the FIFO is full; imem_ack low holds the write stable.
// Optional feature macro INSTR_ENC_ILLEGAL_TRAP_EN: drop illegal mnemonics and flag err.

// Generic single-clock FIFO. Registered storage with a combinational head.
// Latency: a word pushed at edge N is visible on pop_dat after edge N.
// Backpressure: the caller must not push when full or pop when empty.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];

    // Pointer and occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
endmodule

module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              wrapped,
    output logic              err
);
    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wrapped_q, wrapped_d;
    logic [31:0]       enc_dat;
    logic              accept, push, pop;
    logic [31:0]       fifo_dat;
    logic              fifo_full, fifo_empty;
    logic              start_ok;

    // Field packing; unlisted mnemonics become an all-zero word (NOP).
    always_comb begin
        enc_dat = '0;
        case (in_op)
            4'd0:  enc_dat = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            4'd1:  enc_dat = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            4'd2:  enc_dat = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            4'd3:  enc_dat = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            4'd4:  enc_dat = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
            4'd5:  enc_dat = {6'h08, in_rs, in_rt, in_imm};
            4'd6:  enc_dat = {6'h0D, in_rs, in_rt, in_imm};
            4'd7:  enc_dat = {6'h23, in_rs, in_rt, in_imm};
            4'd8:  enc_dat = {6'h2B, in_rs, in_rt, in_imm};
            4'd9:  enc_dat = {6'h04, in_rs, in_rt, in_imm};
            4'd10: enc_dat = {6'h05, in_rs, in_rt, in_imm};
            4'd11: enc_dat = {6'h02, in_target};
            4'd12: enc_dat = {6'h03, in_target};
            default: enc_dat = '0;
        endcase
    end

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign busy     = !fifo_empty || we_q;
    assign start_ok = start && !busy;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    logic op_illegal;
    logic err_q, err_d;

    assign op_illegal = (in_op >= 4'd13);
    assign push       = accept && !op_illegal;

    // Sticky illegal-mnemonic flag; a new session clears it, a same-cycle trap wins.
    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end
        if (accept && op_illegal) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (enc_dat),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Write FSM: load the output register from the FIFO head, hold it until ack, chain back-to-back.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wrapped_d = wrapped_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wdata_d = fifo_dat;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (imem_ack) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (&addr_q) begin
                        wrapped_d = 1'b1;
                    end
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        wdata_d = fifo_dat;
                    end else begin
                        we_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Only reachable while idle with an empty FIFO, so it never races a write.
        if (start_ok) begin
            addr_d    = BASE;
            wrapped_d = 1'b0;
        end
    end

    // FSM and output registers; reset abandons any pending write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= BASE;
            wdata_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign wrapped    = wrapped_q;
endmodule
